// File: rtl/sprite_move_sequencer_if.sv
// Wall-tile map read port used by the sprite motion controller.
// Latency: the wall bit for an address strobed in cycle N is valid in cycle N+1.
// Backpressure: none; the map answers every strobe, one read per cycle.
// Signals:
//   map_rd   - tile read strobe (driven by the sequencer)
//   map_addr - tile index, row*64 + col (driven by the sequencer)
//   map_bit  - wall bit for the previous cycle's address (driven by the map)
interface sprite_move_sequencer_if;
  logic        map_rd;
  logic [11:0] map_addr;
  logic        map_bit;

  modport master (
    output map_rd,
    output map_addr,
    input  map_bit
  );

  modport slave (
    input  map_rd,
    input  map_addr,
    output map_bit
  );
endinterface

// File: rtl/sprite_move_sequencer.sv
// Per-frame sprite motion controller: key or bounce move, four-corner wall check, commit or bounce.
// Latency: tick in T, map reads T+1..T+4, decision in T+5, new position/collision visible in T+6.
// Backpressure: a frame_tick arriving while busy is dropped, never queued.
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   frame_tick                 - one-cycle pulse per video frame
//   key_left/right/up/down     - held-key levels, priority left > right > up > down
//   sprite_w, sprite_h         - bounding box extent (right edge x+w, bottom edge y+h)
//   init_x, init_y             - position loaded while reset is high
//   map                        - wall-tile map read port (master side)
//   pos_x, pos_y               - committed top-left position
//   bouncing                   - one-hot {L,R,U,D} active bounce direction, 0 when idle
//   collision                  - one-cycle pulse when a candidate move is rejected
//   busy                       - high while a check is in flight
module sprite_move_sequencer #(
  parameter int STEP          = 2,
  parameter int BOUNCE_FRAMES = 8,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    key_left,
  input  logic                    key_right,
  input  logic                    key_up,
  input  logic                    key_down,
  input  logic [9:0]              sprite_w,
  input  logic [9:0]              sprite_h,
  input  logic [9:0]              init_x,
  input  logic [9:0]              init_y,
  sprite_move_sequencer_if.master map,
  output logic [9:0]              pos_x,
  output logic [9:0]              pos_y,
  output logic [3:0]              bouncing,
  output logic                    collision,
  output logic                    busy
);

  localparam int CNT_W = $clog2(BOUNCE_FRAMES + 1);

  localparam logic [10:0]      STEP_V   = 11'(STEP);
  localparam logic [10:0]      X_LIMIT  = 11'(SCREEN_W - 1);
  localparam logic [10:0]      Y_LIMIT  = 11'(SCREEN_H - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // One-hot direction encoding shared by dir and bouncing: {L,R,U,D}.
  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       k;           // corner index being strobed in CHK
  logic [10:0]      cx;          // registered candidate position
  logic [10:0]      cy;
  logic [3:0]       dir;         // direction of the move under check
  logic             is_bounce;   // move under check came from an active bounce
  logic             hit;         // OR of wall bits returned so far
  logic [CNT_W-1:0] bounce_cnt;

  // Tile index of a pixel coordinate: (y/10)*64 + x/10.
  function automatic logic [11:0] tile_of(input logic [10:0] x, input logic [10:0] y);
    logic [11:0] col;
    logic [11:0] row;
    col = {1'b0, x / 11'd10};
    row = {1'b0, y / 11'd10};
    return (row << 6) + col;
  endfunction

  // Bounce runs the opposite way of the blocked move: swap L/R and U/D.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // ---------------------------------------------------------------
  // Direction pick: an active bounce overrides all keys.
  // ---------------------------------------------------------------
  logic [3:0] next_dir;
  logic       next_is_bounce;

  always_comb begin
    next_dir       = 4'b0000;
    next_is_bounce = 1'b0;
    if (bounce_cnt != '0) begin
      next_dir       = bouncing;
      next_is_bounce = 1'b1;
    end else if (key_left) begin
      next_dir = DIR_L;
    end else if (key_right) begin
      next_dir = DIR_R;
    end else if (key_up) begin
      next_dir = DIR_U;
    end else if (key_down) begin
      next_dir = DIR_D;
    end
  end

  // ---------------------------------------------------------------
  // Candidate position, 11-bit so pos+STEP cannot wrap before the clamp.
  // ---------------------------------------------------------------
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] wx;
  logic [10:0] hy;
  logic [10:0] max_x;
  logic [10:0] max_y;
  logic [10:0] sum_x;
  logic [10:0] sum_y;
  logic [10:0] nx;
  logic [10:0] ny;

  assign px    = {1'b0, pos_x};
  assign py    = {1'b0, pos_y};
  assign wx    = {1'b0, sprite_w};
  assign hy    = {1'b0, sprite_h};
  assign sum_x = px + STEP_V;
  assign sum_y = py + STEP_V;

  // A sprite at least as wide as the screen can only sit at the origin.
  assign max_x = (wx >= X_LIMIT) ? 11'd0 : X_LIMIT - wx;
  assign max_y = (hy >= Y_LIMIT) ? 11'd0 : Y_LIMIT - hy;

  always_comb begin
    nx = px;
    ny = py;
    if (next_dir[3]) begin
      nx = (px < STEP_V) ? 11'd0 : px - STEP_V;
    end else if (next_dir[2]) begin
      nx = (sum_x > max_x) ? max_x : sum_x;
    end else if (next_dir[1]) begin
      ny = (py < STEP_V) ? 11'd0 : py - STEP_V;
    end else if (next_dir[0]) begin
      ny = (sum_y > max_y) ? max_y : sum_y;
    end
  end

  // ---------------------------------------------------------------
  // Corner for the next strobe. Corner order TL, TR, BL, BR means
  // index bit 0 selects the right edge and bit 1 the bottom edge.
  // ---------------------------------------------------------------
  logic [1:0]  k_next;
  logic [10:0] corner_x;
  logic [10:0] corner_y;
  logic        hit_final;

  assign k_next    = k + 2'd1;
  assign corner_x  = k_next[0] ? cx + wx : cx;
  assign corner_y  = k_next[1] ? cy + hy : cy;
  // Corner 3's wall bit arrives during LAST and is folded in here.
  assign hit_final = hit | map.map_bit;

  // ---------------------------------------------------------------
  // Sequencer with registered outputs.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= 2'd0;
      cx           <= 11'd0;
      cy           <= 11'd0;
      dir          <= 4'b0000;
      is_bounce    <= 1'b0;
      hit          <= 1'b0;
      bounce_cnt   <= '0;
      pos_x        <= init_x;
      pos_y        <= init_y;
      bouncing     <= 4'b0000;
      collision    <= 1'b0;
      busy         <= 1'b0;
      map.map_rd   <= 1'b0;
      map.map_addr <= 12'd0;
    end else begin
      collision <= 1'b0;
      case (state)
        IDLE: begin
          // No direction means no reads and no busy cycle at all.
          if (frame_tick && (next_dir != 4'b0000)) begin
            state        <= CHK;
            k            <= 2'd0;
            cx           <= nx;
            cy           <= ny;
            dir          <= next_dir;
            is_bounce    <= next_is_bounce;
            hit          <= 1'b0;
            busy         <= 1'b1;
            map.map_rd   <= 1'b1;
            // TL is strobed straight from the unregistered candidate so
            // the first read lines up with the first CHK cycle.
            map.map_addr <= tile_of(nx, ny);
          end
        end

        CHK: begin
          // The bit on the port belongs to the previous corner; nothing
          // is pending yet in the first CHK cycle.
          if (k != 2'd0) begin
            hit <= hit | map.map_bit;
          end
          if (k == 2'd3) begin
            state      <= LAST;
            map.map_rd <= 1'b0;
          end else begin
            map.map_addr <= tile_of(corner_x, corner_y);
          end
          k <= k_next;
        end

        LAST: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!hit_final) begin
            pos_x <= cx[9:0];
            pos_y <= cy[9:0];
            if (is_bounce) begin
              bounce_cnt <= bounce_cnt - CNT_ONE;
              if (bounce_cnt == CNT_ONE) begin
                bouncing <= 4'b0000;
              end
            end
          end else begin
            collision <= 1'b1;
            if (is_bounce) begin
              // A blocked bounce ends the bounce outright rather than
              // reversing again, so the sprite cannot oscillate.
              bounce_cnt <= '0;
              bouncing   <= 4'b0000;
            end else begin
              bounce_cnt <= CNT_LOAD;
              bouncing   <= opposite(dir);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_move_sequencer.sv
// Self-checking bench for sprite_move_sequencer: directed scenarios plus randomized frames.
// Latency: each frame is ticked in T and its outcome checked in T+6.
// Backpressure: exercised by a second tick issued while the first check is in flight.
module tb_sprite_move_sequencer;

  localparam int STEP = 2;
  localparam int BF   = 8;
  localparam int SW   = 640;
  localparam int SH   = 480;

  // Model direction codes.
  localparam int D_NONE = 0;
  localparam int D_L    = 1;
  localparam int D_R    = 2;
  localparam int D_U    = 3;
  localparam int D_D    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic [9:0] sprite_w = 10'd20;
  logic [9:0] sprite_h = 10'd20;
  logic [9:0] init_x = 10'd100;
  logic [9:0] init_y = 10'd200;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [3:0] bouncing;
  logic       collision;
  logic       busy;

  sprite_move_sequencer_if map_if ();

  sprite_move_sequencer #(
    .STEP(STEP), .BOUNCE_FRAMES(BF), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .sprite_w(sprite_w), .sprite_h(sprite_h), .init_x(init_x), .init_y(init_y),
    .map(map_if),
    .pos_x(pos_x), .pos_y(pos_y), .bouncing(bouncing), .collision(collision), .busy(busy)
  );

  always #5 clk = ~clk;

  // Wall map with a 1-cycle read latency.
  bit wall [0:3071];
  always @(posedge clk) begin
    map_if.map_bit <= map_if.map_rd ? wall[map_if.map_addr] : 1'b0;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_x, m_y, m_cnt, m_bdir;

  function automatic bit wall_at(int x, int y);
    int idx;
    idx = (y / 10) * 64 + x / 10;
    if (idx < 0 || idx > 3071) return 1'b0;
    return wall[idx];
  endfunction

  function automatic logic [3:0] onehot(int d);
    case (d)
      D_L:     return 4'b1000;
      D_R:     return 4'b0100;
      D_U:     return 4'b0010;
      D_D:     return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int opp(int d);
    case (d)
      D_L:     return D_R;
      D_R:     return D_L;
      D_U:     return D_D;
      D_D:     return D_U;
      default: return D_NONE;
    endcase
  endfunction

  // Advance the model by one frame using the currently driven keys.
  task automatic model_frame(output bit exp_col);
    int d, nx, ny, w, h, lim;
    bit bnc, hit;
    w = int'(sprite_w);
    h = int'(sprite_h);
    exp_col = 1'b0;
    bnc = (m_cnt != 0);
    if (bnc)            d = m_bdir;
    else if (key_left)  d = D_L;
    else if (key_right) d = D_R;
    else if (key_up)    d = D_U;
    else if (key_down)  d = D_D;
    else                d = D_NONE;
    if (d == D_NONE) return;
    nx = m_x;
    ny = m_y;
    case (d)
      D_L: nx = (m_x < STEP) ? 0 : m_x - STEP;
      D_R: begin lim = (SW - 1 - w < 0) ? 0 : SW - 1 - w; nx = (m_x + STEP > lim) ? lim : m_x + STEP; end
      D_U: ny = (m_y < STEP) ? 0 : m_y - STEP;
      default: begin lim = (SH - 1 - h < 0) ? 0 : SH - 1 - h; ny = (m_y + STEP > lim) ? lim : m_y + STEP; end
    endcase
    hit = wall_at(nx, ny) | wall_at(nx + w, ny) | wall_at(nx, ny + h) | wall_at(nx + w, ny + h);
    if (!hit) begin
      m_x = nx;
      m_y = ny;
      if (bnc) begin
        m_cnt--;
        if (m_cnt == 0) m_bdir = D_NONE;
      end
    end else begin
      exp_col = 1'b1;
      if (bnc) begin
        m_cnt  = 0;
        m_bdir = D_NONE;
      end else begin
        m_cnt  = BF;
        m_bdir = opp(d);
      end
    end
  endtask

  task automatic set_keys(bit l, bit r, bit u, bit d);
    key_left = l; key_right = r; key_up = u; key_down = d;
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 3072; i++) wall[i] = 1'b0;
  endtask

  task automatic do_reset(int x, int y);
    init_x = 10'(x);
    init_y = 10'(y);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    m_x = x; m_y = y; m_cnt = 0; m_bdir = D_NONE;
  endtask

  // Drives a tick in cycle T and returns at the negedge inside T+1.
  task automatic pulse_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    sprite_w = 10'd20; sprite_h = 10'd20;
    set_keys(0, 0, 0, 0);
    clear_walls();
    do_reset(100, 200);
    total++; if (pos_x !== 10'd100) begin bad++; $display("FAIL reset_pos_x got=%0d want=100", pos_x); end
    total++; if (pos_y !== 10'd200) begin bad++; $display("FAIL reset_pos_y got=%0d want=200", pos_y); end
    total++; if (bouncing !== 4'b0000) begin bad++; $display("FAIL reset_bouncing got=%b want=0000", bouncing); end
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b want=0", collision); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (map_if.map_rd !== 1'b0) begin bad++; $display("FAIL reset_map_rd got=%b want=0", map_if.map_rd); end
  endtask

  task automatic test_free_right();
    int exp_addr [4];
    bit ec;
    exp_addr = '{1290, 1292, 1418, 1420};
    do_reset(100, 200);
    set_keys(0, 1, 0, 0);
    model_frame(ec);
    pulse_tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++; if (map_if.map_rd !== 1'b1) begin bad++; $display("FAIL free_map_rd[%0d] got=%b want=1", i, map_if.map_rd); end
      total++; if (map_if.map_addr !== 12'(exp_addr[i])) begin bad++; $display("FAIL free_addr[%0d] got=%0d want=%0d", i, map_if.map_addr, exp_addr[i]); end
    end
    @(negedge clk); // T+5
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL free_busy_last got=%b want=1", busy); end
    total++; if (map_if.map_rd !== 1'b0) begin bad++; $display("FAIL free_rd_last got=%b want=0", map_if.map_rd); end
    @(negedge clk); // T+6
    total++; if (pos_x !== 10'd102) begin bad++; $display("FAIL free_pos_x got=%0d want=102", pos_x); end
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL free_collision got=%b want=0", collision); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL free_busy_done got=%b want=0", busy); end
    set_keys(0, 0, 0, 0);
  endtask

  task automatic test_wall_left();
    bit ec;
    do_reset(100, 200);
    wall[1289] = 1'b1; // TL tile of candidate (98,200)
    set_keys(1, 0, 0, 0);
    model_frame(ec);
    pulse_tick();
    repeat (5) @(negedge clk); // T+6
    total++; if (collision !== 1'b1) begin bad++; $display("FAIL wall_collision got=%b want=1", collision); end
    total++; if (pos_x !== 10'd100) begin bad++; $display("FAIL wall_pos_x got=%0d want=100", pos_x); end
    total++; if (bouncing !== 4'b0100) begin bad++; $display("FAIL wall_bouncing got=%b want=0100", bouncing); end
    @(negedge clk); // T+7
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL wall_collision_pulse got=%b want=0", collision); end
    wall[1289] = 1'b0;
    // key_left stays held: it must be ignored for the whole bounce.
    for (int f = 0; f < BF; f++) begin
      model_frame(ec);
      pulse_tick();
      repeat (5) @(negedge clk);
      total++; if (pos_x !== 10'(m_x)) begin bad++; $display("FAIL bounce_pos_x[%0d] got=%0d want=%0d", f, pos_x, m_x); end
    end
    total++; if (pos_x !== 10'd116) begin bad++; $display("FAIL bounce_end_x got=%0d want=116", pos_x); end
    total++; if (bouncing !== 4'b0000) begin bad++; $display("FAIL bounce_end_dir got=%b want=0000", bouncing); end
    set_keys(0, 0, 0, 0);
  endtask

  task automatic test_edge_priority();
    bit ec;
    do_reset(1, 200);
    set_keys(1, 0, 1, 0);
    model_frame(ec);
    pulse_tick();
    repeat (5) @(negedge clk);
    total++; if (pos_x !== 10'd0) begin bad++; $display("FAIL edge_left_x got=%0d want=0", pos_x); end
    total++; if (pos_y !== 10'd200) begin bad++; $display("FAIL edge_left_y got=%0d want=200", pos_y); end
    sprite_w = 10'd39;
    do_reset(600, 200);
    set_keys(0, 1, 0, 0);
    model_frame(ec);
    pulse_tick();
    repeat (5) @(negedge clk);
    total++; if (pos_x !== 10'd600) begin bad++; $display("FAIL edge_right_x got=%0d want=600", pos_x); end
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL edge_right_col got=%b want=0", collision); end
    sprite_w = 10'd20;
    set_keys(0, 0, 0, 0);
  endtask

  task automatic test_dropped_tick();
    bit ec;
    do_reset(100, 200);
    set_keys(0, 0, 0, 1);
    model_frame(ec);
    pulse_tick();             // T+1
    @(negedge clk);           // T+2
    @(negedge clk); frame_tick = 1'b1; // T+3
    @(negedge clk); frame_tick = 1'b0; // T+4
    @(negedge clk);           // T+5
    @(negedge clk);           // T+6
    total++; if (pos_y !== 10'd202) begin bad++; $display("FAIL drop_pos_y got=%0d want=202", pos_y); end
    @(negedge clk);           // T+7
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
    set_keys(0, 0, 0, 0);
    repeat (6) @(negedge clk);
    total++; if (pos_y !== 10'd202) begin bad++; $display("FAIL drop_pos_y_late got=%0d want=202", pos_y); end
  endtask

  task automatic test_reset_midcheck();
    bit ec;
    do_reset(100, 200);
    set_keys(0, 1, 0, 0);
    model_frame(ec);
    pulse_tick();
    repeat (5) @(negedge clk); // at 102 now
    wall[1290] = 1'b1;         // blocks the next right move at (104,200)
    pulse_tick();              // T+1
    @(negedge clk);            // T+2
    @(negedge clk); reset = 1'b1; // T+3
    @(negedge clk); reset = 1'b0; // T+4
    m_x = 100; m_y = 200; m_cnt = 0; m_bdir = D_NONE;
    set_keys(0, 0, 0, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (map_if.map_rd !== 1'b0) begin bad++; $display("FAIL midrst_map_rd got=%b want=0", map_if.map_rd); end
    total++; if (pos_x !== 10'd100) begin bad++; $display("FAIL midrst_pos_x got=%0d want=100", pos_x); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (collision !== 1'b0) begin bad++; $display("FAIL midrst_collision[%0d] got=%b want=0", i, collision); end
    end
    total++; if (bouncing !== 4'b0000) begin bad++; $display("FAIL midrst_bouncing got=%b want=0000", bouncing); end
    wall[1290] = 1'b0;
  endtask

  task automatic test_random();
    bit ec;
    int w, h;
    for (int run = 0; run < 3; run++) begin
      w = $urandom_range(6, 40);
      h = $urandom_range(6, 40);
      sprite_w = 10'(w);
      sprite_h = 10'(h);
      clear_walls();
      for (int i = 0; i < 200; i++) wall[$urandom_range(0, 3071)] = 1'b1;
      do_reset($urandom_range(0, SW - 1 - w), $urandom_range(0, SH - 1 - h));
      for (int f = 0; f < 50; f++) begin
        set_keys(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        model_frame(ec);
        pulse_tick();
        repeat (5) @(negedge clk);
        total++; if (pos_x !== 10'(m_x)) begin bad++; $display("FAIL rand_pos_x[%0d.%0d] got=%0d want=%0d", run, f, pos_x, m_x); end
        total++; if (pos_y !== 10'(m_y)) begin bad++; $display("FAIL rand_pos_y[%0d.%0d] got=%0d want=%0d", run, f, pos_y, m_y); end
        total++; if (bouncing !== onehot(m_bdir)) begin bad++; $display("FAIL rand_bouncing[%0d.%0d] got=%b want=%b", run, f, bouncing, onehot(m_bdir)); end
        total++; if (collision !== ec) begin bad++; $display("FAIL rand_collision[%0d.%0d] got=%b want=%b", run, f, collision, ec); end
      end
    end
    set_keys(0, 0, 0, 0);
    clear_walls();
  endtask

  initial begin
    test_reset();
    test_free_right();
    test_wall_left();
    test_edge_priority();
    test_dropped_tick();
    test_reset_midcheck();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_move_sequencer.md
# sprite_move_sequencer

Per-frame motion controller for the player sprite. On each frame tick it forms a candidate position from the key inputs, or from an active bounce, and checks the four corners of the candidate bounding box. The checks go one per cycle through a single-ported, 1-cycle-latency read port on the 64x48 wall-tile map. It then either commits the move or starts a fixed-length bounce in the opposite direction. It sits between the keycode decoder and the sprite drawer, and owns the sprite position registers.

## Interface
- STEP, 2: pixels moved per frame, normal or bounce.
- BOUNCE_FRAMES, 8: number of frames a bounce lasts.
- SCREEN_W, 640 / SCREEN_H, 480: playfield size in pixels.
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- key_left, key_right, key_up, key_down  in  1 each  held-key levels.
- sprite_w, sprite_h  in  10  bounding-box extent in pixels (right edge = x+w, bottom edge = y+h).
- init_x, init_y  in  10  position loaded at reset.
- map_rd  out  1  tile read strobe.
- map_addr  out  12  tile index = row*64 + col.
- map_bit  in  1  wall bit for the address strobed in the previous cycle.
- pos_x, pos_y  out  10  committed sprite position (top-left corner).
- bouncing  out  4  one-hot {L,R,U,D}: active bounce direction; 0 when no bounce.
- collision  out  1  one-cycle pulse when a candidate move is rejected.
- busy  out  1  high while a check is in progress.

## Operation
- States: IDLE, CHK, LAST.
- IDLE:
  - On frame_tick, pick the move direction. If bounce_cnt is nonzero, use the bounce direction. Otherwise use the highest-priority held key: left > right > up > down.
  - If there is no direction, stay in IDLE and issue no reads.
- Candidate position (11-bit arithmetic, clamped):
  - left: cx = (pos_x < STEP) ? 0 : pos_x - STEP.
  - right: cx = min(pos_x + STEP, SCREEN_W-1-sprite_w).
  - up and down: same rules on y, using SCREEN_H and sprite_h.
  - The candidate is registered on entry to CHK.
- CHK (4 cycles, index k = 0..3):
  - map_rd = 1 each cycle.
  - map_addr is the tile of corner k, in order TL(cx,cy), TR(cx+w,cy), BL(cx,cy+h), BR(cx+w,cy+h).
  - Tile = (y/10)*64 + x/10, using constant division by 10. The clamp guarantees map_addr ≤ 3071.
  - Each cycle after the first, map_bit is ORed into a hit register.
- LAST (1 cycle):
  - map_rd = 0; ORs in the corner-3 map_bit.
  - Decides as below, then returns to IDLE.
- Decision when hit = 0:
  - pos ← candidate.
  - If bouncing, bounce_cnt decrements; bouncing clears when it reaches 0.
- Decision when hit = 1 on a key move:
  - pos is unchanged and collision pulses.
  - bounce_cnt ← BOUNCE_FRAMES; bouncing ← opposite of the attempted direction.
- Decision when hit = 1 on a bounce move:
  - pos is unchanged and collision pulses.
  - bounce_cnt ← 0 and bouncing ← 0, so the sprite does not oscillate.
- Keys are ignored while bounce_cnt ≠ 0.
- A frame_tick arriving while busy is dropped. It is not queued.
- Reset in any state:
  - State returns to IDLE and any in-flight check is abandoned.
  - pos ← (init_x, init_y); bounce_cnt, bouncing, collision, busy, map_rd, map_addr ← 0.

## Timing
- frame_tick is sampled in cycle T.
- CHK occupies T+1..T+4 with map_rd high; map_bit for corner k is valid in T+2+k.
- LAST is T+5.
- pos, bouncing and collision are registered at the end of T+5 and are visible in T+6.
- collision is high for exactly cycle T+6.
- busy is high T+1..T+5. The next tick can be accepted in T+6.
- All outputs are registered. Worst-case latency is 6 cycles from tick to position update.

## Test plan
- Reset with init_x=100, init_y=200 → pos=(100,200); bouncing, collision, busy, map_rd = 0.
- Free move right (w=h=20, pos=(100,200), map all 0), key_right + tick:
  - map_addr sequence 1290, 1292, 1418, 1420 over T+1..T+4.
  - pos_x=102 at T+6; no collision.
- Wall hit moving left (map_bit=1 on the TL read), pos=(100,200):
  - pos unchanged; collision pulses at T+6; bouncing=R.
  - Next 8 clear ticks → pos_x=116, then bouncing=0.
- Edge clamp and priority:
  - pos_x=1, key_left+key_up held → moves left only, pos_x=0.
  - pos_x=600, w=39, key_right → pos_x=600 (max_x = 639-39 = 600).
- Ignored inputs: extra frame_tick at T+3 is dropped (one move only); keys pressed during a bounce have no effect.
- Reset asserted at T+3 → IDLE next cycle; pos=init, busy=0, no collision pulse.
